fetch_stage: RTL and testbench

//  Instruction-fetch stage directly upstream of imem. Owns the PC and drives imem's combinational pc_addr.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 53 +++++
 rtl/fetch_stage.sv | 99 +++++++++
 tb/tb_fetch_stage.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants, FSM encodings and the fetch-entry layout for the instruction-fetch stage.
package fetch_pkg;

  localparam int XLEN = 64;

  localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;
  localparam logic [3:0]  EXC_INSTR_MISALIGNED = 4'd0;
  localparam logic [3:0]  EXC_INSTR_ACCESS     = 4'd1;

  localparam logic [0:0] ST_FETCH = 1'b0;
  localparam logic [0:0] ST_HALT  = 1'b1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            exc_en;
    logic [3:0]      exc_code;
    logic [XLEN-1:0] exc_val;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small registered FIFO between fetch and decode; accepts a push on a full cycle when a pop frees a slot.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(do_push);
      rd_ptr_q <= rd_ptr_q + AW'(do_pop);
      count_q  <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: storage is not reset; count_q gates every read, so stale data is never observed.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, forms {pc, instr, exception} entries and queues them for decode.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] pc_addr,
  input  logic [31:0]     imem_instr,
  input  logic            imem_exc_en,
  input  logic [3:0]      imem_exc_code,
  input  logic [XLEN-1:0] imem_exc_val,
  input  logic            redirect_en,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic            out_exc_en,
  output logic [3:0]      out_exc_code,
  output logic [XLEN-1:0] out_exc_val
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [0:0]      state_q, state_d;
  fetch_entry_t    enq_entry, head, shown;
  logic            fifo_empty, fifo_full, push, pop;

  assign pc_addr   = pc_q;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign push      = (state_q == ST_FETCH) && !redirect_en && (!fifo_full || pop);

  // A misaligned PC is reported without trusting imem's response.
  always_comb begin
    enq_entry       = '0;
    enq_entry.pc    = pc_q;
    enq_entry.instr = imem_instr;
    if (pc_q[1:0] != 2'b00) begin
      enq_entry.instr    = NOP_INSTR;
      enq_entry.exc_en   = 1'b1;
      enq_entry.exc_code = EXC_INSTR_MISALIGNED;
      enq_entry.exc_val  = pc_q;
    end else if (imem_exc_en) begin
      enq_entry.instr    = NOP_INSTR;
      enq_entry.exc_en   = 1'b1;
      enq_entry.exc_code = imem_exc_code;
      enq_entry.exc_val  = imem_exc_val;
    end
  end

  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    if (redirect_en) begin
      pc_d    = redirect_pc;
      state_d = ST_FETCH;
    end else if (push) begin
      pc_d = pc_q + XLEN'(4);
      if (enq_entry.exc_en) state_d = ST_HALT;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      state_q <= ST_FETCH;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_en),
    .push  (push),
    .pop   (pop),
    .din   (enq_entry),
    .dout  (head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign shown        = fifo_empty ? '0 : head;
  assign out_pc       = shown.pc;
  assign out_instr    = shown.instr;
  assign out_exc_en   = shown.exc_en;
  assign out_exc_code = shown.exc_code;
  assign out_exc_val  = shown.exc_val;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a scoreboard of expected decode-side entries.
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam logic [XLEN-1:0] RESET_PC = 64'h8000_0000;
  localparam int              DEPTH    = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [XLEN-1:0] pc_addr;
  logic [31:0]     imem_instr;
  logic            imem_exc_en;
  logic [3:0]      imem_exc_code;
  logic [XLEN-1:0] imem_exc_val;
  logic            redirect_en;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_instr;
  logic            out_exc_en;
  logic [3:0]      out_exc_code;
  logic [XLEN-1:0] out_exc_val;

  logic            fault_arm;
  logic [XLEN-1:0] fault_pc;

  int n_assert = 0;
  int n_fail   = 0;

  fetch_entry_t    sb[$];
  logic [XLEN-1:0] m_pc;
  logic            m_halt;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_addr       (pc_addr),
    .imem_instr    (imem_instr),
    .imem_exc_en   (imem_exc_en),
    .imem_exc_code (imem_exc_code),
    .imem_exc_val  (imem_exc_val),
    .redirect_en   (redirect_en),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_instr     (out_instr),
    .out_exc_en    (out_exc_en),
    .out_exc_code  (out_exc_code),
    .out_exc_val   (out_exc_val)
  );

  function automatic logic [31:0] imem_word(logic [XLEN-1:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  // Behavioural imem: answers whatever address the DUT presents.
  assign imem_instr    = imem_word(pc_addr);
  assign imem_exc_en   = fault_arm && (pc_addr == fault_pc);
  assign imem_exc_code = EXC_INSTR_ACCESS;
  assign imem_exc_val  = pc_addr;

  function automatic fetch_entry_t exp_entry(logic [XLEN-1:0] a);
    fetch_entry_t e;
    e = '0;
    e.pc = a;
    if (a[1:0] != 2'b00) begin
      e.instr = 32'h0000_0013; e.exc_en = 1'b1; e.exc_code = 4'd0; e.exc_val = a;
    end else if (fault_arm && a == fault_pc) begin
      e.instr = 32'h0000_0013; e.exc_en = 1'b1; e.exc_code = 4'd1; e.exc_val = a;
    end else begin
      e.instr = imem_word(a);
    end
    return e;
  endfunction

  task automatic check(string tag, logic [199:0] obs, logic [199:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_pc   = RESET_PC;
    m_halt = 1'b0;
  endtask

  // Called at a falling edge with this cycle's inputs applied; returns at the next falling edge.
  task automatic step();
    fetch_entry_t e;
    bit pop, enq;
    check("pc_addr", pc_addr, m_pc);
    check("out_valid", out_valid, sb.size() > 0);
    if (sb.size() > 0) begin
      check("out_pc", out_pc, sb[0].pc);
      check("out_instr", out_instr, sb[0].instr);
      check("out_exc", {out_exc_en, out_exc_code}, {sb[0].exc_en, sb[0].exc_code});
      check("out_exc_val", out_exc_val, sb[0].exc_val);
    end else begin
      check("empty_zero", {out_pc, out_instr, out_exc_en, out_exc_code, out_exc_val}, '0);
    end
    pop = (sb.size() > 0) && out_ready;
    if (redirect_en) begin
      sb.delete();
      m_pc   = redirect_pc;
      m_halt = 1'b0;
    end else begin
      enq = !m_halt && (sb.size() < DEPTH || pop);
      if (pop) void'(sb.pop_front());
      if (enq) begin
        e = exp_entry(m_pc);
        sb.push_back(e);
        m_pc = m_pc + 64'd4;
        if (e.exc_en) m_halt = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic redirect(logic [XLEN-1:0] a);
    redirect_en = 1'b1;
    redirect_pc = a;
    step();
    redirect_en = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    out_ready   = 1'b1;
    redirect_en = 1'b0;
    redirect_pc = '0;
    fault_arm   = 1'b0;
    fault_pc    = '0;
    model_reset();

    @(negedge clk);
    check("rst_pc_addr", pc_addr, RESET_PC);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_zero", {out_pc, out_instr, out_exc_en, out_exc_code, out_exc_val}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming at one instruction per cycle.
    run(6);

    // Backpressure: FIFO fills and PC stalls.
    out_ready = 1'b0;
    run(5);
    out_ready = 1'b1;
    run(4);

    // Redirect while full with decode accepting.
    out_ready = 1'b0;
    run(3);
    out_ready = 1'b1;
    redirect(64'h8000_0100);
    run(3);

    // Back-to-back redirects: the later target wins.
    redirect_en = 1'b1;
    redirect_pc = 64'h8000_0400;
    step();
    redirect_pc = 64'h8000_0800;
    step();
    redirect_en = 1'b0;
    run(3);

    // PC wraps past the top of the address space.
    redirect(64'hFFFF_FFFF_FFFF_FFF8);
    run(4);

    // imem access fault halts fetch until a redirect.
    fault_arm = 1'b1;
    fault_pc  = 64'h8000_2000;
    redirect(64'h8000_1FF8);
    run(4);
    out_ready = 1'b0;
    run(2);
    fault_arm = 1'b0;
    out_ready = 1'b1;
    run(4);

    // Recovery from HALT.
    redirect(64'h8000_0000);
    run(4);

    // Misaligned target, then asynchronous reset mid-stream.
    redirect(64'h8000_0102);
    run(3);
    redirect(64'h8000_0300);
    out_ready = 1'b0;
    run(2);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_pc_addr", pc_addr, RESET_PC);
    check("mid_rst_zero", {out_pc, out_instr, out_exc_en, out_exc_code, out_exc_val}, '0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    run(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
